// File: rtl/spi_byte_master_if.sv
// Byte-oriented SPI master bus: host-side handshake plus the serial pins.
interface spi_byte_master_if;
  logic [7:0] spi_data_tx;
  logic       spi_txn_start;
  logic       spi_force_clock;
  logic [7:0] spi_data_rx;
  logic       spi_txn_done;
  logic       spi_busy;
  logic       spi_clk;
  logic       spi_mosi;
  logic       spi_miso;

  modport master (
    input  spi_data_tx, spi_txn_start, spi_force_clock, spi_miso,
    output spi_data_rx, spi_txn_done, spi_busy, spi_clk, spi_mosi
  );

  modport slave (
    output spi_data_tx, spi_txn_start, spi_force_clock, spi_miso,
    input  spi_data_rx, spi_txn_done, spi_busy, spi_clk, spi_mosi
  );
endinterface

// File: rtl/spi_byte_master.sv
// Mode-0 SPI master moving one byte per start, MSB first, plus a free-running SCK mode.
module spi_byte_master #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_byte_master_if.master  bus
);

  localparam logic [7:0] DivM1 = 8'(CLK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StShift, StFree} state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [4:0] half_q, half_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic [7:0] rx_q, rx_d;
  logic       clk_q, clk_d;
  logic       mosi_q, mosi_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      half_q  <= 5'd0;
      tx_sh_q <= 8'd0;
      rx_sh_q <= 8'd0;
      rx_q    <= 8'd0;
      clk_q   <= 1'b0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      tx_sh_q <= tx_sh_d;
      rx_sh_q <= rx_sh_d;
      rx_q    <= rx_d;
      clk_q   <= clk_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    tx_sh_d = tx_sh_q;
    rx_sh_d = rx_sh_q;
    rx_d    = rx_q;
    clk_d   = clk_q;
    mosi_d  = mosi_q;
    done_d  = 1'b0;
    busy_d  = busy_q;

    unique case (state_q)
      StIdle: begin
        clk_d  = 1'b0;
        busy_d = 1'b0;
        // Free-run request wins over a simultaneous start.
        if (bus.spi_force_clock) begin
          state_d = StFree;
          busy_d  = 1'b1;
          mosi_d  = 1'b1;
          cnt_d   = DivM1;
        end else if (bus.spi_txn_start) begin
          state_d = StShift;
          busy_d  = 1'b1;
          tx_sh_d = bus.spi_data_tx;
          mosi_d  = bus.spi_data_tx[7];
          rx_sh_d = 8'd0;
          cnt_d   = DivM1;
          half_d  = 5'd0;
        end
      end

      StShift: begin
        // half_q == 16: SCK has returned low; spend one more cycle, then complete.
        if (half_q == 5'd16) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          rx_d    = rx_sh_q;
        end else if (cnt_q == 8'd0) begin
          cnt_d  = DivM1;
          clk_d  = ~clk_q;
          half_d = half_q + 5'd1;
          if (!clk_q) begin
            rx_sh_d = {rx_sh_q[6:0], bus.spi_miso};
          end else if (half_q != 5'd15) begin
            mosi_d  = tx_sh_q[6];
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      StFree: begin
        mosi_d = 1'b1;
        if (cnt_q == 8'd0) begin
          cnt_d = DivM1;
          clk_d = ~clk_q;
          // Only leave on a falling boundary so every high pulse is a full half-period.
          if (clk_q && !bus.spi_force_clock) begin
            state_d = StIdle;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign bus.spi_data_rx  = rx_q;
  assign bus.spi_txn_done = done_q;
  assign bus.spi_busy     = busy_q;
  assign bus.spi_clk      = clk_q;
  assign bus.spi_mosi     = mosi_q;

endmodule

// File: tb/tb_spi_byte_master.sv
// Bench for spi_byte_master: one instance at CLK_DIV=2, one at CLK_DIV=1, checked against
// expectations derived from transfer length, bit order and byte values.
module tb_spi_byte_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_byte_master_if bus2 ();
  spi_byte_master_if bus1 ();

  spi_byte_master #(.CLK_DIV(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.master));
  spi_byte_master #(.CLK_DIV(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.master));

  // Index 0 drives/observes the CLK_DIV=2 instance, index 1 the CLK_DIV=1 instance.
  logic       start_r[2];
  logic       force_r[2];
  logic [7:0] tx_r[2];
  logic       loop_r[2];
  logic [7:0] miso_byte_r[2];
  int         base_r[2];
  logic [7:0] exp_rx[2];

  int         rise0 = 0;
  int         rise1 = 0;
  logic [7:0] seen0 = 8'd0;
  logic [7:0] seen1 = 8'd0;

  int checks = 0;
  int failures = 0;

  function automatic logic miso_bit(input logic [7:0] b, input int n);
    if (n >= 0 && n < 8) return b[7-n];
    return 1'b0;
  endfunction

  assign bus2.spi_txn_start   = start_r[0];
  assign bus2.spi_force_clock = force_r[0];
  assign bus2.spi_data_tx     = tx_r[0];
  assign bus2.spi_miso = loop_r[0] ? bus2.spi_mosi : miso_bit(miso_byte_r[0], rise0 - base_r[0]);
  assign bus1.spi_txn_start   = start_r[1];
  assign bus1.spi_force_clock = force_r[1];
  assign bus1.spi_data_tx     = tx_r[1];
  assign bus1.spi_miso = loop_r[1] ? bus1.spi_mosi : miso_bit(miso_byte_r[1], rise1 - base_r[1]);

  // Record MOSI as the slave would see it on each SCK rising edge.
  always @(posedge bus2.spi_clk) begin
    rise0 <= rise0 + 1;
    seen0 <= {seen0[6:0], bus2.spi_mosi};
  end
  always @(posedge bus1.spi_clk) begin
    rise1 <= rise1 + 1;
    seen1 <= {seen1[6:0], bus1.spi_mosi};
  end

  logic       done_w[2], busy_w[2], sck_w[2], mosi_w[2];
  logic [7:0] rx_w[2], seen_w[2];
  int         rise_w[2];
  assign done_w[0] = bus2.spi_txn_done;
  assign done_w[1] = bus1.spi_txn_done;
  assign busy_w[0] = bus2.spi_busy;
  assign busy_w[1] = bus1.spi_busy;
  assign sck_w[0]  = bus2.spi_clk;
  assign sck_w[1]  = bus1.spi_clk;
  assign mosi_w[0] = bus2.spi_mosi;
  assign mosi_w[1] = bus1.spi_mosi;
  assign rx_w[0]   = bus2.spi_data_rx;
  assign rx_w[1]   = bus1.spi_data_rx;
  assign seen_w[0] = seen0;
  assign seen_w[1] = seen1;
  assign rise_w[0] = rise0;
  assign rise_w[1] = rise1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input int s, input string tag);
    chk($sformatf("%s_sck%0d", tag, s), 32'(sck_w[s]), 32'd0);
    chk($sformatf("%s_mosi%0d", tag, s), 32'(mosi_w[s]), 32'd0);
    chk($sformatf("%s_rx%0d", tag, s), 32'(rx_w[s]), 32'd0);
    chk($sformatf("%s_done%0d", tag, s), 32'(done_w[s]), 32'd0);
    chk($sformatf("%s_busy%0d", tag, s), 32'(busy_w[s]), 32'd0);
  endtask

  // One byte transfer: completion expected 1 + 16*div cycles after the accepting edge.
  task automatic xfer(input int s, input logic [7:0] txb, input logic [7:0] mb,
                      input logic lb, input logic hold);
    int         div = (s == 0) ? 2 : 1;
    int         exp_done = 1 + 16 * div;
    logic [7:0] exp_byte = lb ? txb : mb;
    int         m;
    @(negedge clk);
    tx_r[s]        = txb;
    miso_byte_r[s] = mb;
    loop_r[s]      = lb;
    base_r[s]      = rise_w[s];
    start_r[s]     = 1'b1;
    @(posedge clk);
    #1;
    start_r[s] = hold;
    tx_r[s]    = 8'($urandom);
    for (int k = 1; k <= exp_done; k++) begin
      @(posedge clk);
      #1;
      if (k < exp_done) begin
        m = k / div;
        chk($sformatf("busy%0d_k%0d", s, k), 32'(busy_w[s]), 32'd1);
        chk($sformatf("done%0d_k%0d", s, k), 32'(done_w[s]), 32'd0);
        chk($sformatf("rx_hold%0d_k%0d", s, k), 32'(rx_w[s]), 32'(exp_rx[s]));
        chk($sformatf("sck%0d_k%0d", s, k), 32'(sck_w[s]), 32'(m % 2));
      end else begin
        chk($sformatf("done%0d_end", s), 32'(done_w[s]), 32'd1);
        chk($sformatf("busy%0d_end", s), 32'(busy_w[s]), 32'd0);
        chk($sformatf("rx%0d_end", s), 32'(rx_w[s]), 32'(exp_byte));
        chk($sformatf("sck%0d_end", s), 32'(sck_w[s]), 32'd0);
      end
      // Start/force/data wiggles mid-transfer must have no effect.
      if (k == 3) force_r[s] = 1'b1;
      if (k == 6) force_r[s] = 1'b0;
    end
    exp_rx[s] = exp_byte;
    chk($sformatf("rises%0d", s), 32'(rise_w[s] - base_r[s]), 32'd8);
    chk($sformatf("mosi_bits%0d", s), 32'(seen_w[s]), 32'(txb));
    if (!hold) begin
      @(posedge clk);
      #1;
      chk($sformatf("done%0d_pulse", s), 32'(done_w[s]), 32'd0);
      chk($sformatf("busy%0d_after", s), 32'(busy_w[s]), 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      start_r[i]     = 1'b0;
      force_r[i]     = 1'b0;
      tx_r[i]        = 8'd0;
      loop_r[i]      = 1'b0;
      miso_byte_r[i] = 8'd0;
      base_r[i]      = 0;
      exp_rx[i]      = 8'd0;
    end
    #2;
    chk_reset_outputs(0, "por");
    chk_reset_outputs(1, "por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed loopback and fixed-MISO transfers.
    xfer(0, 8'hA5, 8'h00, 1'b1, 1'b0);
    xfer(1, 8'hFF, 8'h3C, 1'b0, 1'b0);

    // Back-to-back with start held across the done cycle.
    xfer(0, 8'h01, 8'($urandom), 1'b1, 1'b1);
    xfer(0, 8'h80, 8'($urandom), 1'b1, 1'b0);

    for (int i = 0; i < 6; i++) begin
      xfer(i % 2, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    end

    // Free-run with a simultaneous start on entry and a start pulse mid-way.
    @(negedge clk);
    force_r[0] = 1'b1;
    start_r[0] = 1'b1;
    tx_r[0]    = 8'($urandom);
    @(posedge clk);
    #1;
    start_r[0] = 1'b0;
    chk("free_entry_busy", 32'(busy_w[0]), 32'd1);
    chk("free_entry_mosi", 32'(mosi_w[0]), 32'd1);
    chk("free_entry_sck", 32'(sck_w[0]), 32'd0);
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("free_sck_k%0d", k), 32'(sck_w[0]), 32'((k / 2) % 2));
      chk($sformatf("free_busy_k%0d", k), 32'(busy_w[0]), 32'd1);
      chk($sformatf("free_mosi_k%0d", k), 32'(mosi_w[0]), 32'd1);
      chk($sformatf("free_done_k%0d", k), 32'(done_w[0]), 32'd0);
      chk($sformatf("free_rx_k%0d", k), 32'(rx_w[0]), 32'(exp_rx[0]));
      if (k == 7) start_r[0] = 1'b1;
      if (k == 8) start_r[0] = 1'b0;
    end
    @(negedge clk);
    force_r[0] = 1'b0;
    @(posedge clk);
    #1;
    chk("free_exit_high_sck", 32'(sck_w[0]), 32'd1);
    chk("free_exit_high_busy", 32'(busy_w[0]), 32'd1);
    @(posedge clk);
    #1;
    chk("free_exit_sck", 32'(sck_w[0]), 32'd0);
    chk("free_exit_busy", 32'(busy_w[0]), 32'd0);
    chk("free_exit_mosi", 32'(mosi_w[0]), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("idle_sck_k%0d", k), 32'(sck_w[0]), 32'd0);
      chk($sformatf("idle_done_k%0d", k), 32'(done_w[0]), 32'd0);
      chk($sformatf("idle_busy_k%0d", k), 32'(busy_w[0]), 32'd0);
    end

    // Asynchronous reset ten cycles into a transfer.
    @(negedge clk);
    tx_r[0]    = 8'hC3;
    loop_r[0]  = 1'b1;
    start_r[0] = 1'b1;
    @(posedge clk);
    #1;
    start_r[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs(0, "midrst");
    chk_reset_outputs(1, "midrst");
    exp_rx[0] = 8'd0;
    exp_rx[1] = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("postrst_done_k%0d", k), 32'(done_w[0]), 32'd0);
      chk($sformatf("postrst_busy_k%0d", k), 32'(busy_w[0]), 32'd0);
    end
    xfer(0, 8'h5A, 8'($urandom), 1'b0, 1'b0);
    xfer(1, 8'($urandom), 8'($urandom), 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
